// File: rtl/aes192_core_arbiter.sv
// rtl/aes192_core_arbiter.sv - round-robin arbiter sharing one AES-192 core between requesters
module aes192_core_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 40,
  localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_state,
  input  logic [NUM_REQ*192-1:0] req_key,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [127:0]           rsp_data,
  output logic                   rsp_err,
  output logic                   aes_start,
  output logic [127:0]           aes_state,
  output logic [191:0]           aes_key,
  input  logic [127:0]           aes_out,
  input  logic                   aes_out_valid,
  output logic                   busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state, state_n;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_q;
  logic [127:0]   op_state;
  logic [191:0]   op_key;
  logic [127:0]   result;
  logic           err_q;
  logic [CW-1:0]  tmo_cnt;
  logic           arm;

  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;
  int             cand_int;
  logic           qualify;
  logic           timeout;

  // Round-robin search: first valid requester starting at ptr, wrapping modulo NUM_REQ
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand_int    = 0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_int = (int'(ptr) + k) % NUM_REQ;
      cand     = IDW'(cand_int);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // A result only counts once out_valid has been seen low in this WAIT (stale level from the previous job)
  assign qualify = arm && aes_out_valid;
  assign timeout = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and outputs; operands and response are gated to zero outside their owning state
  always_comb begin
    state_n   = state;
    req_ready = '0;
    aes_start = 1'b0;
    aes_state = '0;
    aes_key   = '0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (!rst && grant_found) begin
          req_ready = NUM_REQ'(1) << grant_id;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        aes_start = 1'b1;
        aes_state = op_state;
        aes_key   = op_key;
        state_n   = WAIT;
      end
      WAIT: begin
        if (qualify || timeout) state_n = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_data  = err_q ? '0 : result;
        rsp_err   = err_q;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: capture on accept, clear operands after issue, collect result or timeout in WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      id_q     <= '0;
      op_state <= '0;
      op_key   <= '0;
      result   <= '0;
      err_q    <= 1'b0;
      tmo_cnt  <= '0;
      arm      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_state <= req_state[grant_id*128 +: 128];
            op_key   <= req_key[grant_id*192 +: 192];
            id_q     <= grant_id;
            ptr      <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          end
        end
        ISSUE: begin
          op_state <= '0;
          op_key   <= '0;
          arm      <= 1'b0;
          tmo_cnt  <= '0;
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (!aes_out_valid) arm <= 1'b1;
          if (qualify) begin
            result <= aes_out;
            err_q  <= 1'b0;
          end else if (timeout) begin
            result <= '0;
            err_q  <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            result <= '0;
            err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes192_core_arbiter.sv
// tb/tb_aes192_core_arbiter.sv - directed self-checking bench for aes192_core_arbiter
module tb_aes192_core_arbiter;

  localparam logic [191:0] NIST_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] NIST_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] NIST_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [511:0] req_state;
  logic [767:0] req_key;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic         aes_start;
  logic [127:0] aes_state;
  logic [191:0] aes_key;
  logic [127:0] aes_out;
  logic         aes_out_valid;
  logic         busy;

  logic [127:0] pts  [4];
  logic [191:0] keys [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes192_core_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(40)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_state(req_state), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .aes_start(aes_start), .aes_state(aes_state), .aes_key(aes_key),
    .aes_out(aes_out), .aes_out_valid(aes_out_valid),
    .busy(busy)
  );

  always_comb begin
    req_state = '0;
    req_key   = '0;
    for (int i = 0; i < 4; i++) begin
      req_state[i*128 +: 128] = pts[i];
      req_key[i*192 +: 192]   = keys[i];
    end
  end

  // Core model: NIST vector maps to its known ciphertext, anything else to a simple mix
  function automatic logic [127:0] core_f(input logic [127:0] pt, input logic [191:0] k);
    if (pt == NIST_PT && k == NIST_KEY) return NIST_CT;
    return pt ^ k[191:64] ^ 128'hc3c3_5a5a_0f0f_a5a5_3c3c_f0f0_9696_6969;
  endfunction

  // 26-cycle core stub whose out_valid lingers with the old result for two cycles after a new start
  int           cyc       = 0;
  int           start_cyc = 0;
  int           diff;
  logic         have_job  = 1'b0;
  logic         have_prev = 1'b0;
  logic         dead      = 1'b0;
  logic [127:0] lat_pt    = '0;
  logic [191:0] lat_key   = '0;
  logic [127:0] prev_ct   = '0;
  logic [127:0] cur_ct;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (aes_start) begin
      start_cyc <= cyc;
      lat_pt    <= aes_state;
      lat_key   <= aes_key;
      prev_ct   <= cur_ct;
      have_prev <= have_job;
      have_job  <= 1'b1;
    end
  end

  always_comb begin
    diff          = cyc - start_cyc;
    cur_ct        = core_f(lat_pt, lat_key);
    aes_out_valid = !dead && have_job && ((diff >= 26) || (have_prev && diff <= 2));
    aes_out       = (diff >= 26) ? cur_ct : prev_ct;
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, aes_start, aes_state, aes_key, busy}, '0);
  endtask

  task automatic do_job(input logic [3:0] mask, input int exp_id, input logic exp_err,
                        input int exp_lat, input bit bp);
    int           n;
    logic [127:0] exp_ct;
    logic [1:0]   hid;
    logic [127:0] hdata;
    logic         herr;
    exp_ct    = exp_err ? 128'h0 : core_f(pts[exp_id], keys[exp_id]);
    req_valid = mask;
    rsp_ready = !bp;
    #1;
    n = 0;
    while (req_ready == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    check("grant", req_ready, 4'b0001 << exp_id);
    tick();
    req_valid = 4'b0;
    #1;
    check("issue_start", aes_start, 1'b1);
    check("issue_key", aes_key, keys[exp_id]);
    check("issue_state", aes_state, pts[exp_id]);
    check("issue_ready", req_ready, 4'b0);
    n = 0;
    do begin
      tick();
      n++;
      if (!rsp_valid) begin
        check("wait_start_low", aes_start, 1'b0);
        check("wait_key_zero", aes_key, 192'h0);
        check("wait_rsp_data_zero", rsp_data, 128'h0);
      end
    end while (!rsp_valid && n < 100);
    check("latency", n, exp_lat);
    check("rsp_id", rsp_id, exp_id[1:0]);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_data", rsp_data, exp_ct);
    if (bp) begin
      hid       = rsp_id;
      hdata     = rsp_data;
      herr      = rsp_err;
      req_valid = 4'hf;
      #1;
      repeat (10) begin
        tick();
        check("bp_valid", rsp_valid, 1'b1);
        check("bp_id", rsp_id, hid);
        check("bp_data", rsp_data, hdata);
        check("bp_err", rsp_err, herr);
        check("bp_req_ready", req_ready, 4'b0);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_valid_at_rise", rsp_valid, 1'b1);
      tick();
      check("bp_rsp_done", rsp_valid, 1'b0);
      check("bp_next_ready", req_ready != 4'b0, 1'b1);
      req_valid = 4'b0;
      #1;
    end else begin
      tick();
      check("rsp_done", rsp_valid, 1'b0);
      check("idle_busy", busy, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst       = 1'b1;
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    keys[0] = 192'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc;
    pts[0]  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    keys[1] = 192'hdead_beef_0000_1111_2222_3333_4444_5555_6666_7777_8888_9999;
    pts[1]  = 128'hffff_0000_ffff_0000_1234_5678_9abc_def0;
    keys[2] = NIST_KEY;
    pts[2]  = NIST_PT;
    keys[3] = 192'h0f0f_0f0f_f0f0_f0f0_1357_9bdf_2468_ace0_a5a5_a5a5_5a5a_5a5a;
    pts[3]  = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    tick();
    tick();
    check_all_zero("reset_outputs");
    rst = 1'b0;
    #1;
    check("reset_busy", busy, 1'b0);

    do_job(4'b0100, 2, 1'b0, 27, 1'b0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int j = 0; j < 5; j++) do_job(4'hf, j % 4, 1'b0, 27, 1'b0);

    do_job(4'b0010, 1, 1'b0, 27, 1'b0);
    do_job(4'b1000, 3, 1'b0, 27, 1'b0);

    do_job(4'b0001, 0, 1'b0, 27, 1'b1);

    dead = 1'b1;
    do_job(4'b0010, 1, 1'b1, 41, 1'b0);
    dead = 1'b0;
    do_job(4'b0010, 1, 1'b0, 27, 1'b0);

    req_valid = 4'b0100;
    #1;
    check("mr_grant", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0;
    repeat (6) tick();
    check("mr_busy_before", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_all_zero("mr_outputs_zero");
    seen = 0;
    repeat (60) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("mr_no_response", seen, 0);
    do_job(4'hf, 0, 1'b0, 27, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes192_core_arbiter.md
Name: aes192_core_arbiter

Overview:
- Shares one secure_aes_192 pipelined encryption core between NUM_REQ requesters.
- Each requester presents a 128-bit plaintext and a 192-bit key over a valid/ready handshake.
- The block picks a requester by round-robin, issues a single start pulse to the core, waits for the core's result with a timeout guard, and returns the ciphertext with the requester ID.
- Operand key/state lines to the core are driven non-zero only during the issue cycle, and the response bus is zero whenever it is not valid, so secret material is not left on shared wires.

Parameters:
NUM_REQ, 4, number of requesters (2..8); ID width is IDW = clog2(NUM_REQ), minimum 1.
TIMEOUT_CYCLES, 40, number of WAIT cycles without a qualifying aes_out_valid before an error response is returned (must be greater than 27).

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  one-hot grant/accept; a transfer occurs when req_valid[i] & req_ready[i]
req_state  input  NUM_REQ*128  plaintexts; requester i occupies bits [i*128 +: 128]
req_key  input  NUM_REQ*192  keys; requester i occupies bits [i*192 +: 192]
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  IDW  requester index for this response
rsp_data  output  128  ciphertext; all zeros unless rsp_valid=1 and rsp_err=0
rsp_err  output  1  timeout flag, meaningful only while rsp_valid=1
aes_start  output  1  to core start input (the core acts on the rising edge)
aes_state  output  128  to core state input
aes_key  output  192  to core key input
aes_out  input  128  from core out
aes_out_valid  input  1  from core out_valid (level; stays high until the next start)
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, checked at the clk edge): FSM goes to IDLE and the round-robin pointer goes to 0. All of the following clear to 0: operand registers, result register, timeout counter, arm flag. Every output is 0. A reset mid-job abandons that job and produces no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational and one-hot: the first i with req_valid[i]=1, searching from ptr upward with wrap-around. If no request is valid, req_ready=0.
  - On a transfer, capture state, key and ID, set ptr to (winner+1) mod NUM_REQ, and go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE (exactly 1 cycle):
  - aes_start=1, aes_state and aes_key driven from the operand registers.
  - Operand registers clear to 0 at the end of this cycle. aes_state and aes_key are 0 in every other state.
  - Clear the arm flag and the timeout counter, then go to WAIT.
  - aes_start is 0 in every other state. This guarantees at least one low cycle between starts, which the core needs to see a rising edge.
- WAIT:
  - The core's out_valid from the previous job may still be high on the first WAIT cycle(s). It is ignored until aes_out_valid has been sampled 0 at least once in this WAIT; that sample sets arm=1.
  - Qualifying result: arm=1 and aes_out_valid=1. Capture aes_out into the result register, set err=0, go to RESP.
  - The timeout counter increments every WAIT cycle. When it reaches TIMEOUT_CYCLES-1 with no qualifying result, set result=0, err=1, go to RESP.
  - If a qualifying result and timeout occur in the same cycle, the result wins (err=0).
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that handshake: the result register clears to 0, the state returns to IDLE, and rsp_valid=0 on the next cycle.
  - Backpressure may hold RESP indefinitely; the core is not restarted meanwhile.
- Latency with the 26-cycle core:
  - Accept in cycle A, aes_start in A+1.
  - aes_out_valid first qualifies in A+27.
  - rsp_valid is high from A+28.
  - Earliest next accept is the cycle after the rsp handshake.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0,...
- Width rules: the ID is zero-extended into rsp_id; ptr wraps modulo NUM_REQ (non-power-of-two NUM_REQ is legal).

Test Plan:
- Single job: after reset, req_valid=4'b0100 with a NIST-style key/plaintext → req_ready=4'b0100 in cycle A, aes_start=1 only in A+1, rsp_valid in A+28 with rsp_id=2, rsp_err=0, and rsp_data equal to the reference-model ciphertext. aes_key=0 in every cycle except A+1.
- Round-robin: all four requesters held valid with rsp_ready=1 → grant order 0,1,2,3,0. No requester is granted twice before all the others are granted.
- Stale out_valid: two back-to-back jobs with the core's out_valid still high from job 1 when job 2 enters WAIT → job 2's response carries job 2's ciphertext, not job 1's, at A2+28.
- Backpressure: rsp_ready=0 for 10 cycles in RESP → rsp_id, rsp_data and rsp_err stay stable and req_ready stays 0. The handshake occurs in the cycle rsp_ready rises; req_ready becomes possible on the next cycle.
- Timeout: core stub that never raises aes_out_valid → rsp_valid after TIMEOUT_CYCLES=40 WAIT cycles with rsp_err=1 and rsp_data=0; the next request is served normally.
- Mid-job reset: rst asserted for 1 cycle during WAIT → all outputs 0 the following cycle, no response ever issued for the abandoned job, and ptr=0, so requester 0 wins the next contention.
